// File: rtl/eth_phy_10g_link_pkg.sv
// State encodings and helpers shared by the 10G PHY link sequencer and its timer.
package eth_phy_10g_link_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED    = 3'd0,
        ST_RESET       = 3'd1,
        ST_WAIT_LOCK   = 3'd2,
        ST_WAIT_STATUS = 3'd3,
        ST_UP          = 3'd4,
        ST_BACKOFF     = 3'd5,
        ST_FAILED      = 3'd6
    } link_state_e;

    // Backoff exponent: the attempt count, capped so the wait stops growing.
    function automatic int unsigned backoff_shift(input logic [3:0] retries, input int unsigned cap);
        int unsigned r;
        r = 32'(retries);
        return (r > cap) ? cap : r;
    endfunction

endpackage

// File: rtl/eth_phy_10g_link_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
// Load takes effect on the next edge; a load value of N-1 gives N cycles before expiry.
module eth_phy_10g_link_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] value,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/eth_phy_10g_link_seq.sv
// Link bring-up/recovery sequencer for eth_phy_10g: PHY reset, lock/status waits, backoff, drop filter.
// All outputs registered one cycle behind the state register; no backpressure, inputs sampled every cycle.
module eth_phy_10g_link_seq
    import eth_phy_10g_link_pkg::*;
#(
    parameter int RESET_CYCLES      = 16,
    parameter int LOCK_TIMEOUT      = 1024,
    parameter int STATUS_TIMEOUT    = 4096,
    parameter int BACKOFF_BASE      = 64,
    parameter int MAX_BACKOFF_SHIFT = 4,
    parameter int MAX_RETRIES       = 7,
    parameter int DROP_FILTER       = 4,
    parameter int CNT_WIDTH         = 16
) (
    input  logic        rx_clk,
    input  logic        rx_rst_n,
    input  logic        cfg_enable,
    input  logic        cfg_restart,
    input  logic        rx_block_lock,
    input  logic        rx_status,
    input  logic        rx_high_ber,
    input  logic        serdes_rx_reset_req,
    input  logic [6:0]  rx_error_count,
    output logic        phy_rst,
    output logic        tx_local_fault,
    output logic        link_up,
    output logic [2:0]  link_state,
    output logic [3:0]  retry_count,
    output logic [15:0] down_events,
    output logic [31:0] err_total
);

    localparam int DROP_W = $clog2(DROP_FILTER + 1);
    localparam logic [CNT_WIDTH-1:0] RESET_LOAD  = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LOAD   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STATUS_LOAD = CNT_WIDTH'(STATUS_TIMEOUT - 1);

    link_state_e          state_q, state_d;
    logic [3:0]           retry_q, retry_d, retry_inc;
    logic [DROP_W-1:0]    drop_run;
    logic                 drop_now, drop_evt;
    logic                 go_reset, fail;
    logic                 tmr_load, tmr_expired;
    logic [CNT_WIDTH-1:0] tmr_value, backoff_load;
    logic [32:0]          err_sum;
    logic                 unused_high_ber;

    // High BER only matters through rx_status, which the PHY already drops.
    assign unused_high_ber = rx_high_ber;

    assign retry_inc    = retry_q + 4'd1;
    assign backoff_load = CNT_WIDTH'((BACKOFF_BASE << backoff_shift(retry_inc, MAX_BACKOFF_SHIFT)) - 1);
    assign err_sum      = {1'b0, err_total} + {26'd0, rx_error_count};

    eth_phy_10g_link_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk     (rx_clk),
        .rst_n   (rx_rst_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        drop_now  = 1'b0;
        go_reset  = 1'b0;
        fail      = 1'b0;
        if (!cfg_enable) begin
            state_d  = ST_DISABLED;
            retry_d  = '0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_DISABLED: go_reset = 1'b1;
                ST_RESET: begin
                    if (cfg_restart) begin
                        go_reset = 1'b1;
                    end else if (tmr_expired) begin
                        state_d   = ST_WAIT_LOCK;
                        tmr_load  = 1'b1;
                        tmr_value = LOCK_LOAD;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (cfg_restart) begin
                        go_reset = 1'b1;
                    end else if (serdes_rx_reset_req || tmr_expired) begin
                        fail = 1'b1;
                    end else if (rx_block_lock) begin
                        state_d   = ST_WAIT_STATUS;
                        tmr_load  = 1'b1;
                        tmr_value = STATUS_LOAD;
                    end
                end
                ST_WAIT_STATUS: begin
                    if (cfg_restart) begin
                        go_reset = 1'b1;
                    end else if (serdes_rx_reset_req || tmr_expired || !rx_block_lock) begin
                        fail = 1'b1;
                    end else if (rx_status) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end
                end
                ST_UP: begin
                    if (cfg_restart) begin
                        go_reset = 1'b1;
                    end else if (serdes_rx_reset_req ||
                                 (!rx_status && drop_run == DROP_W'(DROP_FILTER - 1))) begin
                        drop_now = 1'b1;
                        go_reset = 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (cfg_restart || tmr_expired) begin
                        go_reset = 1'b1;
                    end
                end
                ST_FAILED: begin
                    if (cfg_restart) begin
                        go_reset = 1'b1;
                        retry_d  = '0;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase

            if (go_reset) begin
                state_d   = ST_RESET;
                tmr_load  = 1'b1;
                tmr_value = RESET_LOAD;
            end
            if (fail) begin
                retry_d = retry_inc;
                if (retry_inc == 4'(MAX_RETRIES)) begin
                    state_d = ST_FAILED;
                end else begin
                    state_d   = ST_BACKOFF;
                    tmr_load  = 1'b1;
                    tmr_value = backoff_load;
                end
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            state_q  <= ST_DISABLED;
            retry_q  <= '0;
            drop_run <= '0;
            drop_evt <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            drop_evt <= drop_now;
            if (state_q == ST_UP && !rx_status) begin
                drop_run <= drop_run + 1'b1;
            end else begin
                drop_run <= '0;
            end
        end
    end

    // Outputs follow the state register by one cycle so every output comes straight from a flop.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            phy_rst        <= 1'b1;
            tx_local_fault <= 1'b1;
            link_up        <= 1'b0;
            link_state     <= 3'd0;
            retry_count    <= 4'd0;
            down_events    <= 16'd0;
            err_total      <= 32'd0;
        end else begin
            phy_rst        <= (state_q != ST_WAIT_LOCK) && (state_q != ST_WAIT_STATUS) &&
                              (state_q != ST_UP);
            tx_local_fault <= (state_q != ST_UP);
            link_up        <= (state_q == ST_UP);
            link_state     <= state_q;
            retry_count    <= retry_q;
            if (drop_evt && down_events != 16'hFFFF) begin
                down_events <= down_events + 16'd1;
            end
            if (state_q == ST_UP) begin
                err_total <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
            end
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_link_seq.sv
// Directed bench for the link sequencer: stimulus queues the expected output tuple for each
// link_state change; a monitor pops and compares whenever link_state moves.
module tb_eth_phy_10g_link_seq;

    typedef struct {
        logic [2:0]  st;
        logic        phy;
        logic        lu;
        logic        tlf;
        logic [3:0]  retry;
        logic [15:0] down;
        logic [31:0] err;
        int          dur;   // samples spent in the previous state, -1 = not checked
        int          run;   // consecutive phy_rst=1 samples before the change, -1 = not checked
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable, cfg_restart;
    logic        rx_block_lock, rx_status, rx_high_ber, serdes_rx_reset_req;
    logic [6:0]  rx_error_count;
    logic        phy_rst, tx_local_fault, link_up;
    logic [2:0]  link_state;
    logic [3:0]  retry_count;
    logic [15:0] down_events;
    logic [31:0] err_total;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   bo[6] = '{128, 256, 512, 1024, 1024, 1024};

    always #5 clk = ~clk;

    eth_phy_10g_link_seq dut (
        .rx_clk              (clk),
        .rx_rst_n            (rst_n),
        .cfg_enable          (cfg_enable),
        .cfg_restart         (cfg_restart),
        .rx_block_lock       (rx_block_lock),
        .rx_status           (rx_status),
        .rx_high_ber         (rx_high_ber),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .rx_error_count      (rx_error_count),
        .phy_rst             (phy_rst),
        .tx_local_fault      (tx_local_fault),
        .link_up             (link_up),
        .link_state          (link_state),
        .retry_count         (retry_count),
        .down_events         (down_events),
        .err_total           (err_total)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic phy, input logic lu, input logic tlf,
                        input logic [3:0] retry, input logic [15:0] down, input logic [31:0] err,
                        input int dur, input int run);
        exp_t e;
        e.st = st; e.phy = phy; e.lu = lu; e.tlf = tlf; e.retry = retry;
        e.down = down; e.err = err; e.dur = dur; e.run = run;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int i;
        i = 0;
        while (link_state != s && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_state", 32'(link_state), 32'(s));
    endtask

    initial begin : monitor
        logic [2:0] prev_st;
        int         dur;
        int         run;
        bit         first;
        exp_t       e;
        prev_st = 3'd0;
        dur     = 0;
        run     = 0;
        first   = 1'b1;
        @(posedge clk);
        forever begin
            @(posedge clk);
            #2;
            if (first || (rst_n && link_state != prev_st)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_fail++;
                    $display("FAIL unexpected_change: got state %0d, required no change", link_state);
                end else begin
                    e = exp_q.pop_front();
                    chk("link_state", 32'(link_state), 32'(e.st));
                    chk("phy_rst", 32'(phy_rst), 32'(e.phy));
                    chk("link_up", 32'(link_up), 32'(e.lu));
                    chk("tx_local_fault", 32'(tx_local_fault), 32'(e.tlf));
                    chk("retry_count", 32'(retry_count), 32'(e.retry));
                    chk("down_events", 32'(down_events), 32'(e.down));
                    chk("err_total", err_total, e.err);
                    if (e.dur >= 0) chk("prev_state_cycles", 32'(dur), 32'(e.dur));
                    if (e.run >= 0) chk("phy_rst_run", 32'(run), 32'(e.run));
                end
                first = 1'b0;
                dur   = 0;
            end
            prev_st = link_state;
            if (!rst_n) begin
                dur = 0;
                run = 0;
            end else begin
                dur++;
                run = phy_rst ? run + 1 : 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d expected entries left", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int i;
        rst_n = 1'b0; cfg_enable = 1'b1; cfg_restart = 1'b0;
        rx_block_lock = 1'b0; rx_status = 1'b0; rx_high_ber = 1'b0;
        serdes_rx_reset_req = 1'b0; rx_error_count = 7'd0;

        // Reset values, then clean bring-up: phy_rst high 17 samples after release.
        push(3'd0, 1, 0, 1, 4'd0, 16'd0, 32'd0, -1, -1);
        push(3'd1, 1, 0, 1, 4'd0, 16'd0, 32'd0, 1, -1);
        push(3'd2, 0, 0, 1, 4'd0, 16'd0, 32'd0, 16, 17);
        push(3'd3, 0, 0, 1, 4'd0, 16'd0, 32'd0, 24, -1);
        push(3'd4, 0, 1, 0, 4'd0, 16'd0, 32'd0, 10, -1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        rx_block_lock = 1'b1;
        repeat (10) @(negedge clk);
        rx_status = 1'b1;
        wait_state(3'd4, 100);

        // Short dip and high BER must not drop the link; then accumulate errors.
        rx_status = 1'b0;
        repeat (3) @(negedge clk);
        rx_status = 1'b1;
        rx_high_ber = 1'b1;
        repeat (5) @(negedge clk);
        rx_high_ber = 1'b0;
        rx_error_count = 7'd100;
        repeat (10) @(negedge clk);
        rx_error_count = 7'd0;

        // Four-cycle dip: drop, back through RESET, lock still present.
        push(3'd1, 1, 0, 1, 4'd0, 16'd1, 32'd1000, -1, -1);
        push(3'd2, 0, 0, 1, 4'd0, 16'd1, 32'd1000, 16, -1);
        push(3'd3, 0, 0, 1, 4'd0, 16'd1, 32'd1000, 1, -1);
        rx_status = 1'b0;
        wait_state(3'd3, 100);

        // Status and SERDES reset request together: failure wins.
        push(3'd5, 1, 0, 1, 4'd1, 16'd1, 32'd1000, -1, -1);
        push(3'd1, 1, 0, 1, 4'd1, 16'd1, 32'd1000, 128, -1);
        push(3'd2, 0, 0, 1, 4'd1, 16'd1, 32'd1000, 16, 144);
        rx_status = 1'b1;
        serdes_rx_reset_req = 1'b1;
        @(negedge clk);
        rx_status = 1'b0;
        serdes_rx_reset_req = 1'b0;
        rx_block_lock = 1'b0;
        wait_state(3'd2, 400);

        // Disable during WAIT_LOCK.
        repeat (5) @(negedge clk);
        push(3'd0, 1, 0, 1, 4'd0, 16'd1, 32'd1000, 7, -1);
        cfg_enable = 1'b0;
        repeat (3) @(negedge clk);

        // Lock never arrives: six growing backoffs, then FAILED.
        push(3'd1, 1, 0, 1, 4'd0, 16'd1, 32'd1000, -1, -1);
        push(3'd2, 0, 0, 1, 4'd0, 16'd1, 32'd1000, 16, -1);
        for (int k = 1; k <= 6; k++) begin
            push(3'd5, 1, 0, 1, 4'(k), 16'd1, 32'd1000, 1024, -1);
            push(3'd1, 1, 0, 1, 4'(k), 16'd1, 32'd1000, bo[k-1], -1);
            push(3'd2, 0, 0, 1, 4'(k), 16'd1, 32'd1000, 16, bo[k-1] + 16);
        end
        push(3'd6, 1, 0, 1, 4'd7, 16'd1, 32'd1000, 1024, -1);
        cfg_enable = 1'b1;
        wait_state(3'd6, 15000);

        // FAILED holds until restart; restart brings the link straight up.
        repeat (20) @(negedge clk);
        rx_block_lock = 1'b1;
        rx_status = 1'b1;
        push(3'd1, 1, 0, 1, 4'd0, 16'd1, 32'd1000, -1, -1);
        push(3'd2, 0, 0, 1, 4'd0, 16'd1, 32'd1000, 16, -1);
        push(3'd3, 0, 0, 1, 4'd0, 16'd1, 32'd1000, 1, -1);
        push(3'd4, 0, 1, 0, 4'd0, 16'd1, 32'd1000, 1, -1);
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
        wait_state(3'd4, 100);

        // Preload near the top of the error counter and push it past the limit.
        @(negedge clk);
        force dut.err_total = 32'hFFFF_FF00;
        #1;
        release dut.err_total;
        rx_error_count = 7'd100;
        repeat (5) @(negedge clk);
        rx_error_count = 7'd0;

        // SERDES reset request in UP counts as a drop.
        push(3'd1, 1, 0, 1, 4'd0, 16'd2, 32'hFFFF_FFFF, -1, -1);
        push(3'd2, 0, 0, 1, 4'd0, 16'd2, 32'hFFFF_FFFF, 16, -1);
        serdes_rx_reset_req = 1'b1;
        rx_block_lock = 1'b0;
        rx_status = 1'b0;
        @(negedge clk);
        serdes_rx_reset_req = 1'b0;

        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("expected_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_link_seq.md
# eth_phy_10g_link_seq

Link bring-up and recovery sequencer for the 10G PHY (`eth_phy_10g`). It drives the PHY reset, waits for block lock and then for `rx_status`, and applies bounded timeouts with exponential backoff between retries. It also filters link drops and forces XGMII local-fault signalling until the link is up. It sits beside `eth_phy_10g` in the RX clock domain and replaces the hand-pulsed PHY resets used in the PHY benches.

## Interface
- `RESET_CYCLES`, 16: cycles `phy_rst` is held per attempt.
- `LOCK_TIMEOUT`, 1024: cycles allowed for `rx_block_lock` after PHY reset release.
- `STATUS_TIMEOUT`, 4096: cycles allowed for `rx_status` after lock.
- `BACKOFF_BASE`, 64: base backoff in cycles.
- `MAX_BACKOFF_SHIFT`, 4: backoff exponent cap.
- `MAX_RETRIES`, 7: failed attempts before the FAILED state.
- `DROP_FILTER`, 4: consecutive cycles with `rx_status` = 0 in UP that declare a link drop.
- `CNT_WIDTH`, 16: width of the timer. Must hold `STATUS_TIMEOUT` and `BACKOFF_BASE << MAX_BACKOFF_SHIFT`.
- `rx_clk` in 1: single clock for all logic.
- `rx_rst_n` in 1: reset, synchronous, active-low.
- `cfg_enable` in 1: sequencer enable. 0 forces DISABLED.
- `cfg_restart` in 1: single-cycle pulse. Leaves FAILED, or forces a new attempt from any other enabled state.
- `rx_block_lock`, `rx_status`, `rx_high_ber` in 1 each: from PHY.
- `serdes_rx_reset_req` in 1: PHY request for a SERDES/PHY reset.
- `rx_error_count` in 7: per-cycle PHY error count.
- `phy_rst` out 1: active-high reset to `eth_phy_10g` (both `rx_rst` and `tx_rst`).
- `tx_local_fault` out 1: 1 means the XGMII TX mux sends local-fault ordered sets instead of MAC data.
- `link_up` out 1: link usable.
- `link_state` out 3: encoded state.
- `retry_count` out 4: failed attempts since the last UP.
- `down_events` out 16: link drops since reset, saturating.
- `err_total` out 32: sum of `rx_error_count` while UP, saturating.

## Operation
- State encodings: DISABLED=0, RESET=1, WAIT_LOCK=2, WAIT_STATUS=3, UP=4, BACKOFF=5, FAILED=6.
- **DISABLED**
  - `phy_rst`=1. `retry_count` and timer cleared.
  - Goes to RESET when `cfg_enable`=1.
- **RESET**
  - `phy_rst`=1 for exactly `RESET_CYCLES` cycles, then WAIT_LOCK with the timer cleared.
- **WAIT_LOCK**
  - `rx_block_lock`=1 → WAIT_STATUS, timer cleared.
  - Timer reaches `LOCK_TIMEOUT`, or `serdes_rx_reset_req`=1 → failure.
- **WAIT_STATUS**
  - `rx_status`=1 → UP, `retry_count` cleared.
  - Timer reaches `STATUS_TIMEOUT`, or `rx_block_lock` falls, or `serdes_rx_reset_req`=1 → failure.
- **Failure**
  - `retry_count`+1.
  - If the new value equals `MAX_RETRIES` → FAILED; otherwise → BACKOFF.
- **BACKOFF**
  - `phy_rst`=1.
  - Waits `BACKOFF_BASE << min(retry_count, MAX_BACKOFF_SHIFT)` cycles, then RESET.
- **UP**
  - `link_up`=1, `tx_local_fault`=0.
  - `err_total` += `rx_error_count` each cycle, saturating at 0xFFFFFFFF.
  - A run of `DROP_FILTER` consecutive cycles with `rx_status`=0, or `serdes_rx_reset_req`=1 → `down_events`+1 (saturating), then RESET.
  - A drop does not increment `retry_count`.
  - `rx_high_ber` alone causes no transition; it acts only through `rx_status`.
- **FAILED**
  - `phy_rst`=1. Stays here until `cfg_restart` or `cfg_enable`=0.
  - `cfg_restart` → RESET with `retry_count` cleared.
- **`tx_local_fault`** = 1 in every state except UP.
- **Priority when events coincide:** `cfg_enable`=0 > `cfg_restart` > `serdes_rx_reset_req` > timeout > success condition.

## Timing
- Reset values:
  - state DISABLED
  - `phy_rst`=1, `tx_local_fault`=1, `link_up`=0
  - `link_state`=0, `retry_count`=0
  - `down_events`=0, `err_total`=0
- All outputs are registered. They change on the cycle after the state transition that causes them.
- First cycle with `rx_rst_n`=1 and `cfg_enable`=1: next state is RESET.
  - `phy_rst` deasserts `RESET_CYCLES`+1 cycles after reset release.
- Lock → WAIT_STATUS takes one cycle. `rx_status` → `link_up`=1 takes 2 cycles (state register plus output register).
- Drop detection: `link_up` falls `DROP_FILTER`+1 cycles after `rx_status` falls.
  - A single 1 in `rx_status` restarts the run count.
- `cfg_enable` deassert mid-operation: DISABLED next cycle and `phy_rst`=1; counters other than `retry_count` are kept.
- `rx_rst_n` asserted mid-operation: full reset next edge.
- Timer saturates and never wraps.

## Structure
- Package `eth_phy_10g_link_pkg`:
  - state encoding constants
  - backoff-shift helper function
- Sub-module `eth_phy_10g_link_timer`: loadable down-counter with `load`, `value`, and `expired` ports. It is shared by the RESET, WAIT_*, and BACKOFF states.
- The FSM, drop filter, and statistics counters live in the top level.

## Test plan
- **Clean bring-up:** `cfg_enable`=1, lock at cycle 40 after reset release, status 10 cycles later → `phy_rst` high for 17 cycles, `link_up`=1, `retry_count`=0.
- **Lock timeout with backoff:** lock never arrives → backoffs of 128, 256, 512, 1024, 1024, 1024 cycles, then FAILED with `retry_count`=7, `phy_rst`=1; `cfg_restart` → RESET.
- **Drop filter:** in UP, `rx_status` 0 for 3 cycles then 1 → no drop; 0 for 4 cycles → `down_events`=1, `link_up`=0, state RESET.
- **Error accumulation:** in UP, `rx_error_count`=100 for 10 cycles → `err_total`=1000. Preload near the maximum → `err_total` saturates at 0xFFFFFFFF.
- **Simultaneous events:** in WAIT_STATUS, `rx_status`=1 and `serdes_rx_reset_req`=1 on the same cycle → failure path, `retry_count`=1, BACKOFF.
- **Disable mid-operation:** `cfg_enable`=0 during WAIT_LOCK → DISABLED next cycle, `phy_rst`=1, `retry_count`=0, `tx_local_fault`=1.
